// File: rtl/alu_sequencer.sv
// Request/result sequencer wrapped around a combinational ALU: captures one operation,
// holds its operands on the ALU inputs for 1 or MUL_CYCLES cycles, then presents the result.
module alu_sequencer #(
    parameter int unsigned MUL_CYCLES = 4,
    parameter logic [3:0]  MUL_OPCODE = 4'b0010
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [3:0]  in_opcode,
    input  logic [4:0]  in_sr_bit,
    input  logic [2:0]  in_sr_cont,
    output logic [31:0] In1,
    output logic [31:0] In2,
    output logic [3:0]  opcode,
    output logic [4:0]  SR_Bit,
    output logic [2:0]  SR_Cont,
    input  logic [31:0] alu_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [3:0]  out_opcode,
    output logic        busy,
    output logic [15:0] op_count
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic       accept;
    logic       finish;
    logic       deliver;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        finish    = 1'b0;
        deliver   = 1'b0;
        case (state)
            IDLE: begin
                // in_ready is masked by rst so a request during reset is never acknowledged
                in_ready = !rst;
                accept   = in_valid && !rst;
                if (accept) state_nxt = EXEC;
            end
            EXEC: begin
                busy   = 1'b1;
                finish = (cnt == 4'd0);
                if (finish) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                deliver   = out_ready;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            In1        <= '0;
            In2        <= '0;
            opcode     <= '0;
            SR_Bit     <= '0;
            SR_Cont    <= '0;
            out_result <= '0;
            out_opcode <= '0;
            op_count   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                In1     <= in_a;
                In2     <= in_b;
                opcode  <= in_opcode;
                SR_Bit  <= in_sr_bit;
                SR_Cont <= in_sr_cont;
                cnt     <= (in_opcode == MUL_OPCODE) ? MUL_LOAD : 4'd0;
            end else if (state == EXEC && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (finish) begin
                out_result <= alu_out;
                out_opcode <= opcode;
            end
            if (deliver) op_count <= op_count + 16'd1;
        end
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 4, meaning EXEC cycles for the multiply opcode (legal range 1..15).
REQ-002 SHALL have parameter MUL_OPCODE, default 4'b0010, meaning the opcode treated as multi-cycle.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have ports in_valid input 1 and in_ready output 1, the request handshake.
REQ-006 SHALL have ports in_a input 32, in_b input 32, in_opcode input 4, in_sr_bit input 5 and in_sr_cont input 3, the request operands, opcode and shift controls.
REQ-007 SHALL have ALU-facing outputs In1 32, In2 32, opcode 4, SR_Bit 5 and SR_Cont 3, driving the combinational ALU.
REQ-008 SHALL have port alu_out  input  32  ALU result (ALU Out).
REQ-009 SHALL have ports out_valid output 1 and out_ready input 1, the result handshake.
REQ-010 SHALL have ports out_result output 32 and out_opcode output 4, the registered result and its opcode.
REQ-011 SHALL have ports busy output 1 (state != IDLE) and op_count output 16 (completed-result counter).

Function
REQ-012 SHALL implement FSM states IDLE, EXEC, DONE; in_ready = 1 only in IDLE.
REQ-013 IDLE: on in_valid && in_ready at an edge, SHALL capture in_a, in_b, in_opcode, in_sr_bit, in_sr_cont into operand registers and go to EXEC.
REQ-014 Operand registers SHALL drive In1, In2, opcode, SR_Bit, SR_Cont directly and hold stable through EXEC and DONE until the next accept.
REQ-015 On accept, cycle counter SHALL load L-1, where L = MUL_CYCLES if in_opcode == MUL_OPCODE, else L = 1.
REQ-016 EXEC: counter SHALL decrement each cycle; at the edge where counter == 0, SHALL register alu_out into out_result, opcode into out_opcode, and go to DONE.
REQ-017 Latency: for an accept at edge k, out_valid SHALL first be high in the cycle after edge k+L (non-mul: after edge k+1; mul default: after edge k+4).
REQ-018 DONE: out_valid = 1, and out_result/out_opcode SHALL hold constant while out_ready = 0 (unbounded backpressure).
REQ-019 DONE with out_ready = 1 at an edge SHALL return to IDLE, deassert out_valid, and increment op_count.
REQ-020 No new request SHALL be accepted in the same cycle as the result handshake; the minimum issue interval is L+2 cycles.
REQ-021 in_valid while in_ready = 0 SHALL be ignored, with no capture and no state change.
REQ-022 op_count SHALL wrap from 16'hFFFF to 16'h0000.
REQ-023 out_result SHALL be exactly the 32-bit alu_out value sampled at the REQ-016 edge, with no extension or truncation by this block.

Reset
REQ-024 rst sampled high SHALL force IDLE, counter = 0, and zero the operand registers, In1, In2, opcode, SR_Bit, SR_Cont, out_result, out_opcode, out_valid and op_count.
REQ-025 In reset: in_ready = 0, busy = 0; in_ready SHALL go to 1 in the first cycle after rst deasserts.
REQ-026 rst during EXEC or DONE SHALL discard the in-flight operation, with no out_valid and no op_count increment.
REQ-027 rst SHALL take priority over any simultaneous in or out handshake.

Verification
REQ-028 Multiply: accept In1=7, In2=6, opcode=4'b0010, ALU model alu_out=In1*In2 -> out_valid after edge k+4, out_result=42, op_count 0->1 on the handshake.
REQ-029 Single-cycle op: opcode=4'b0000, in_a=5, in_b=3, model returns 8 -> out_valid after edge k+1, out_result=8, out_opcode=0.
REQ-030 Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid, out_result and In1/In2 stable, in_ready=0, a new in_valid ignored; release -> IDLE.
REQ-031 Reset mid-multiply: assert rst on the 2nd EXEC cycle -> all outputs 0, out_valid never high, op_count stays 0.
REQ-032 Wrap: preload by issuing 65536 ops (or via force) -> op_count reads 16'h0000 after the 65536th handshake.
REQ-033 Back-to-back: in_valid held high with out_ready=1 -> accepts spaced exactly L+2 cycles, results in issue order.
